// File: rtl/axi_stream_mux_pkg.sv
// Shared definitions for the 2:1 AXI-Stream multiplexer.
package axi_stream_mux_pkg;

    // Default width of tdata on both inputs and the output.
    localparam int DATA_WIDTH_DEFAULT = 8;

    // Source identifiers for the select path.
    typedef enum logic {
        SRC_0 = 1'b0,
        SRC_1 = 1'b1
    } src_e;

    // One stream beat without its handshake signals.
    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0] data;
        logic                          last;
    } beat_t;

    // A beat marks the end of a packet only when it is valid.
    function automatic logic qualified_last(input logic last, input logic valid);
        return last & valid;
    endfunction

endpackage

// File: rtl/axi_stream_mux.sv
// 2:1 AXI-Stream multiplexer with a registered output stage.
// Backpressure reaches only the active input. With PACKET_LOCK=1 the source
// can change only between packets.
module axi_stream_mux
    import axi_stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter bit PACKET_LOCK = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] input_tdata_0,
    input  logic                  input_tvalid_0,
    output logic                  input_tready_0,
    input  logic                  input_tlast_0,
    input  logic [DATA_WIDTH-1:0] input_tdata_1,
    input  logic                  input_tvalid_1,
    output logic                  input_tready_1,
    input  logic                  input_tlast_1,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    output logic                  output_last,
    input  logic                  output_ready
);

    src_e                  active_s;
    src_e                  active_r;
    logic                  in_packet_r;
    logic [DATA_WIDTH-1:0] mux_data_s;
    logic                  mux_valid_s;
    logic                  mux_last_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] output_data_r;
    logic                  output_valid_r;
    logic                  output_last_r;

    // Choose the active source: sel is used directly unless a locked packet is in flight.
    always_comb begin
        active_s = SRC_0;
        if (PACKET_LOCK && in_packet_r) begin
            active_s = active_r;
        end else begin
            active_s = src_e'(sel);
        end
    end

    // Route the active input onto the internal beat path.
    always_comb begin
        mux_data_s  = {DATA_WIDTH{1'b0}};
        mux_valid_s = 1'b0;
        mux_last_s  = 1'b0;
        case (active_s)
            SRC_0: begin
                mux_data_s  = input_tdata_0;
                mux_valid_s = input_tvalid_0;
                mux_last_s  = input_tlast_0;
            end
            SRC_1: begin
                mux_data_s  = input_tdata_1;
                mux_valid_s = input_tvalid_1;
                mux_last_s  = input_tlast_1;
            end
            default: begin
                mux_data_s  = {DATA_WIDTH{1'b0}};
                mux_valid_s = 1'b0;
                mux_last_s  = 1'b0;
            end
        endcase
    end

    // Ready is combinational; the inactive input is always held off.
    assign input_tready_0 = !reset && output_ready && (active_s == SRC_0);
    assign input_tready_1 = !reset && output_ready && (active_s == SRC_1);

    // A beat is consumed when the active input is valid and the consumer is ready.
    assign accept_s = !reset && output_ready && mux_valid_s;

    // Output stage: load only when downstream is ready, otherwise hold every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            output_data_r  <= {DATA_WIDTH{1'b0}};
            output_valid_r <= 1'b0;
            output_last_r  <= 1'b0;
        end else if (output_ready) begin
            output_data_r  <= mux_data_s;
            output_valid_r <= mux_valid_s;
            output_last_r  <= qualified_last(mux_last_s, mux_valid_s);
        end else begin
            output_data_r  <= output_data_r;
            output_valid_r <= output_valid_r;
            output_last_r  <= output_last_r;
        end
    end

    // Track packet boundaries and remember the source so it can be held mid-packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r    <= SRC_0;
            in_packet_r <= 1'b0;
        end else begin
            active_r <= active_s;
            if (accept_s) begin
                in_packet_r <= !mux_last_s;
            end else begin
                in_packet_r <= in_packet_r;
            end
        end
    end

    assign output_data  = output_data_r;
    assign output_valid = output_valid_r;
    assign output_last  = output_last_r;

endmodule

// File: tb/tb_axi_stream_mux.sv
// Directed bench for axi_stream_mux: one free-switching and one packet-locked instance
// share the same stimulus.
module tb_axi_stream_mux;

    logic       clk;
    logic       reset;
    logic       sel;
    logic [7:0] tdata0, tdata1;
    logic       tvalid0, tvalid1, tlast0, tlast1;
    logic       ready;

    logic       a_tready0, a_tready1, a_valid, a_last;
    logic [7:0] a_data;
    logic       b_tready0, b_tready1, b_valid, b_last;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    axi_stream_mux #(.DATA_WIDTH(8), .PACKET_LOCK(1'b0)) dut_free (
        .clk(clk), .reset(reset), .sel(sel),
        .input_tdata_0(tdata0), .input_tvalid_0(tvalid0), .input_tready_0(a_tready0), .input_tlast_0(tlast0),
        .input_tdata_1(tdata1), .input_tvalid_1(tvalid1), .input_tready_1(a_tready1), .input_tlast_1(tlast1),
        .output_data(a_data), .output_valid(a_valid), .output_last(a_last), .output_ready(ready)
    );

    axi_stream_mux #(.DATA_WIDTH(8), .PACKET_LOCK(1'b1)) dut_lock (
        .clk(clk), .reset(reset), .sel(sel),
        .input_tdata_0(tdata0), .input_tvalid_0(tvalid0), .input_tready_0(b_tready0), .input_tlast_0(tlast0),
        .input_tdata_1(tdata1), .input_tvalid_1(tvalid1), .input_tready_1(b_tready1), .input_tlast_1(tlast1),
        .output_data(b_data), .output_valid(b_valid), .output_last(b_last), .output_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; ready = 1'b1;
        tdata0 = 8'h00; tdata1 = 8'h00; tvalid0 = 1'b1; tvalid1 = 1'b0;
        tlast0 = 1'b0; tlast1 = 1'b0;

        // Reset gates ready even when the consumer is ready.
        settle();
        chk("rst_tready0_gated", {31'b0, a_tready0}, 32'd0);
        chk("rst_tready1_gated", {31'b0, a_tready1}, 32'd0);
        step();
        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        ready = 1'b0; tvalid0 = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        chk("rel_data", {24'b0, a_data}, 32'h00);
        chk("rel_valid", {31'b0, a_valid}, 32'd0);
        chk("rel_last", {31'b0, a_last}, 32'd0);
        chk("rel_tready0", {31'b0, a_tready0}, 32'd0);
        chk("rel_tready1", {31'b0, a_tready1}, 32'd0);

        // Select switch with both inputs valid.
        tdata0 = 8'hAA; tdata1 = 8'h55; tvalid0 = 1'b1; tvalid1 = 1'b1; ready = 1'b1; sel = 1'b0;
        settle();
        chk("sw_tready0", {31'b0, a_tready0}, 32'd1);
        chk("sw_tready1", {31'b0, a_tready1}, 32'd0);
        step();
        chk("sw_data0", {24'b0, a_data}, 32'hAA);
        chk("sw_valid0", {31'b0, a_valid}, 32'd1);
        sel = 1'b1;
        settle();
        chk("sw_tready0_off", {31'b0, a_tready0}, 32'd0);
        chk("sw_tready1_on", {31'b0, a_tready1}, 32'd1);
        step();
        chk("sw_data1", {24'b0, a_data}, 32'h55);

        // End of packet on stream 0.
        sel = 1'b0;
        step();
        chk("eop_last0", {31'b0, a_last}, 32'd0);
        chk("eop_data", {24'b0, a_data}, 32'hAA);
        tlast0 = 1'b1;
        step();
        chk("eop_last1", {31'b0, a_last}, 32'd1);
        tlast0 = 1'b0;

        // Flow control: outputs hold while ready is low.
        ready = 1'b0; tdata0 = 8'h3C;
        settle();
        chk("fc_tready0_low", {31'b0, a_tready0}, 32'd0);
        step();
        chk("fc_hold_data", {24'b0, a_data}, 32'hAA);
        chk("fc_hold_last", {31'b0, a_last}, 32'd1);
        ready = 1'b1;
        settle();
        chk("fc_tready0_high", {31'b0, a_tready0}, 32'd1);
        chk("fc_tready1_low", {31'b0, a_tready1}, 32'd0);
        step();
        chk("fc_capture", {24'b0, a_data}, 32'h3C);
        chk("fc_capture_last", {31'b0, a_last}, 32'd0);
        ready = 1'b0; tdata0 = 8'hC3;
        step(); step();
        chk("fc_hold2", {24'b0, a_data}, 32'h3C);
        chk("fc_hold2_tready0", {31'b0, a_tready0}, 32'd0);
        chk("fc_hold2_tready1", {31'b0, a_tready1}, 32'd0);

        // Source 1 under backpressure.
        sel = 1'b1; ready = 1'b1; tdata1 = 8'h55;
        step();
        chk("s1_data", {24'b0, a_data}, 32'h55);
        tdata1 = 8'h66; ready = 1'b0;
        step();
        chk("s1_frozen", {24'b0, a_data}, 32'h55);
        ready = 1'b1;
        step();
        chk("s1_resume", {24'b0, a_data}, 32'h66);
        tvalid1 = 1'b0; tlast1 = 1'b1;
        step();
        chk("s1_invalid_valid", {31'b0, a_valid}, 32'd0);
        chk("s1_invalid_last", {31'b0, a_last}, 32'd0);
        tlast1 = 1'b0;

        // Packet lock: sel flips mid-packet on stream 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        sel = 1'b0; ready = 1'b1;
        tdata0 = 8'hA1; tvalid0 = 1'b1; tlast0 = 1'b0;
        tdata1 = 8'hB1; tvalid1 = 1'b1; tlast1 = 1'b0;
        step();
        chk("lk_first", {24'b0, b_data}, 32'hA1);
        sel = 1'b1; tdata0 = 8'hA2;
        settle();
        chk("lk_tready0_held", {31'b0, b_tready0}, 32'd1);
        chk("lk_tready1_held", {31'b0, b_tready1}, 32'd0);
        chk("free_tready1_switch", {31'b0, a_tready1}, 32'd1);
        step();
        chk("lk_mid", {24'b0, b_data}, 32'hA2);
        chk("free_switched", {24'b0, a_data}, 32'hB1);
        tdata0 = 8'hA3; tlast0 = 1'b1;
        step();
        chk("lk_end_data", {24'b0, b_data}, 32'hA3);
        chk("lk_end_last", {31'b0, b_last}, 32'd1);
        tlast0 = 1'b0;
        settle();
        chk("lk_released_tready1", {31'b0, b_tready1}, 32'd1);
        step();
        chk("lk_stream1", {24'b0, b_data}, 32'hB1);

        // Reset mid-packet abandons the partial packet.
        sel = 1'b0;
        settle();
        chk("lk_pkt1_held", {31'b0, b_tready1}, 32'd1);
        reset = 1'b1;
        step();
        chk("lk_rst_data", {24'b0, b_data}, 32'h00);
        chk("lk_rst_valid", {31'b0, b_valid}, 32'd0);
        reset = 1'b0;
        settle();
        chk("lk_rst_active0", {31'b0, b_tready0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
